aoi_pipe_tgl: RTL and testbench
===============================

Name: aoi_pipe_tgl

Overview:
- Parametrised, pipelined successor to the fixed AND-OR-INVERT cells.
- Implements CH independent AND-OR(-INVERT) channels. Each channel ORs NTERM product terms, and each term is the AND of TERM_W inputs.
- Output polarity is selectable, and the result is registered through a stallable pipeline of depth PIPE.
- Per-channel output-toggle activity counters support power characterisation of switching behaviour.

Parameters:
- CH, 4: number of independent channels.
- NTERM, 3: product terms per channel (range 1..8).
- TERM_W, 2: inputs per product term (range 1..4).
- PIPE, 2: pipeline depth in cycles (range 1..4).
- CNT_W, 16: toggle counter width (range 2..32).

Ports:
- CLK  input  1  clock; all registers use the rising edge.
- RSTB  input  1  asynchronous, active-low reset.
- EN  input  1  pipeline advance enable; 0 = stall, all state holds.
- IN  input  CH*NTERM*TERM_W  term inputs; bit IN[(c*NTERM+t)*TERM_W+b] is input b of term t of channel c.
- INV  input  1  polarity select; 1 = AOI (inverted), 0 = AO (true).
- IN_VLD  input  1  marks IN/INV as valid this cycle.
- QN  output  CH  registered channel results.
- OUT_VLD  output  1  QN holds a valid result.
- TGL_CLR  input  1  synchronous clear of all counters and saturation flags.
- TGL_CNT  output  CH*CNT_W  per-channel toggle counts; channel c occupies [c*CNT_W +: CNT_W].
- TGL_SAT  output  CH  per-channel sticky saturation flags.

Behaviour:
- Function: f[c] = OR over t of (AND over b of the input bits for term t, channel c). Result r[c] = INV ? ~f[c] : f[c]. Evaluated combinationally at the stage-0 input.
- Pipeline: PIPE register stages. Each stage holds a CH-bit result plus a valid bit. INV is folded into the result at entry, so a later INV change never alters data already in flight.
- Advance (EN=1):
  - stage 0 <= {r, IN_VLD};
  - stage k <= stage k-1;
  - the last stage drives QN and OUT_VLD.
- Latency: exactly PIPE advancing cycles from sampling IN to QN.
- Stall (EN=0): every stage, QN, OUT_VLD, counters and flags hold. Inputs are ignored.
- Bubbles: an invalid entry (IN_VLD=0) still propagates, clearing OUT_VLD when it arrives. QN is loaded only when the arriving entry is valid; otherwise QN holds its previous value.
- Reset values (RSTB=0, asynchronous, effective immediately):
  - QN = all ones; OUT_VLD = 0;
  - all stage valid bits = 0 and stage data = all ones;
  - TGL_CNT = 0; TGL_SAT = 0.
- Toggle counting: on each cycle where QN loads a valid value, increment TGL_CNT[c] for every channel whose new bit differs from the current QN[c].
  - The first valid load after reset compares against the reset value (all ones).
- Saturation: a counter at 2^CNT_W-1 does not wrap. It holds, and TGL_SAT[c] is set and stays set.
- TGL_CLR=1 acts regardless of EN. It zeroes all counters and flags. A toggle in the same cycle is dropped, so the counter reads 0 next cycle.
- Reset released mid-operation: no partially flushed data appears. OUT_VLD stays 0 until a fresh valid entry has travelled the full PIPE stages.
- Out-of-range parameters: synthesis/elaboration error via generate-time check.

Test Plan:
1. Reset: RSTB=0 with random IN, EN=1 → QN=4'hF, OUT_VLD=0, TGL_CNT=0, TGL_SAT=0, even while CLK toggles.
2. Latency (CH=4, NTERM=3, TERM_W=2, PIPE=2): IN=24'h000003 (ch0 term0 all ones), INV=1, IN_VLD=1, EN=1 for one cycle → exactly 2 cycles later QN=4'hE, OUT_VLD=1, TGL_CNT[ch0]=1, other counts 0.
3. Stall: during test 2, drop EN for 3 cycles after the input is sampled → QN, OUT_VLD and counts frozen. QN=4'hE appears 2 advancing cycles after sampling.
4. Polarity: IN=0, INV=0, IN_VLD=1 → QN=4'h0 after PIPE cycles, each counter increments by 1. INV changes while data is in flight → the in-flight result is unchanged.
5. Saturation/clear (CNT_W=4): toggle ch1 on every valid load for 20 loads → TGL_CNT[ch1]=15, TGL_SAT[1]=1. Assert TGL_CLR in the same cycle as a toggle → count 0, flag 0 next cycle.
6. Reset mid-flight: valid entry in stage 0, pulse RSTB low for half a cycle → no OUT_VLD=1 within the next PIPE cycles unless new IN_VLD is given. QN stays 4'hF.

Source files
------------

// File: rtl/aoi_pipe_tgl.sv
// Parametrised AND-OR(-INVERT) array with a stallable result pipeline.
// Per-channel counters record how often each registered output bit toggles.
module aoi_pipe_tgl_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             i_clr,
    input  logic             i_tgl,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_tgl) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            // Counter is at max-1 or max: after this toggle it sits at max.
            if (&r_cnt[CNT_W-1:1]) r_sat <= 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;
endmodule

module aoi_pipe_tgl #(
    parameter int CH     = 4,
    parameter int NTERM  = 3,
    parameter int TERM_W = 2,
    parameter int PIPE   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       CLK,
    input  logic                       RSTB,
    input  logic                       EN,
    input  logic [CH*NTERM*TERM_W-1:0] IN,
    input  logic                       INV,
    input  logic                       IN_VLD,
    output logic [CH-1:0]              QN,
    output logic                       OUT_VLD,
    input  logic                       TGL_CLR,
    output logic [CH*CNT_W-1:0]        TGL_CNT,
    output logic [CH-1:0]              TGL_SAT
);
    if (CH < 1 || NTERM < 1 || NTERM > 8 || TERM_W < 1 || TERM_W > 4 ||
        PIPE < 1 || PIPE > 4 || CNT_W < 2 || CNT_W > 32) begin : g_param_err
        $error("aoi_pipe_tgl: parameter out of range");
    end

    logic [CH-1:0][NTERM-1:0] w_term;
    logic [CH-1:0]            w_f;
    logic [CH-1:0]            w_r;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar t = 0; t < NTERM; t++) begin : g_term
            assign w_term[c][t] = &IN[(c*NTERM+t)*TERM_W +: TERM_W];
        end
        assign w_f[c] = |w_term[c];
    end

    assign w_r = INV ? ~w_f : w_f;

    logic [PIPE-1:0][CH-1:0] r_stg_dat;
    logic [PIPE-1:0]         r_vld_pipe;
    logic [PIPE-1:0][CH-1:0] w_nxt_dat;
    logic [PIPE-1:0]         w_nxt_vld;

    assign w_nxt_dat[0] = w_r;
    assign w_nxt_vld[0] = IN_VLD;
    for (genvar k = 1; k < PIPE; k++) begin : g_stg
        assign w_nxt_dat[k] = r_stg_dat[k-1];
        assign w_nxt_vld[k] = r_vld_pipe[k-1];
    end

    // The last stage is the QN register itself; it only takes valid data.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_stg_dat  <= '1;
            r_vld_pipe <= '0;
        end else if (EN) begin
            r_vld_pipe <= w_nxt_vld;
            for (int k = 0; k < PIPE - 1; k++) r_stg_dat[k] <= w_nxt_dat[k];
            if (w_nxt_vld[PIPE-1]) r_stg_dat[PIPE-1] <= w_nxt_dat[PIPE-1];
        end
    end

    assign QN      = r_stg_dat[PIPE-1];
    assign OUT_VLD = r_vld_pipe[PIPE-1];

    logic [CH-1:0] w_tgl;
    assign w_tgl = {CH{EN & w_nxt_vld[PIPE-1]}} & (w_nxt_dat[PIPE-1] ^ QN);

    for (genvar c = 0; c < CH; c++) begin : g_cnt
        aoi_pipe_tgl_cnt #(.CNT_W(CNT_W)) u_cnt (
            .CLK   (CLK),
            .RSTB  (RSTB),
            .i_clr (TGL_CLR),
            .i_tgl (w_tgl[c]),
            .o_cnt (TGL_CNT[c*CNT_W +: CNT_W]),
            .o_sat (TGL_SAT[c])
        );
    end
endmodule

// File: tb/tb_aoi_pipe_tgl.sv
// Directed bench for aoi_pipe_tgl: CH=4, NTERM=3, TERM_W=2, PIPE=2, CNT_W=4.
module tb_aoi_pipe_tgl;
    logic        CLK = 1'b0;
    logic        RSTB = 1'b0;
    logic        EN = 1'b1;
    logic [23:0] IN = '0;
    logic        INV = 1'b0;
    logic        IN_VLD = 1'b0;
    logic [3:0]  QN;
    logic        OUT_VLD;
    logic        TGL_CLR = 1'b0;
    logic [15:0] TGL_CNT;
    logic [3:0]  TGL_SAT;

    int n_chk = 0;
    int n_err = 0;

    aoi_pipe_tgl #(.CH(4), .NTERM(3), .TERM_W(2), .PIPE(2), .CNT_W(4)) dut (
        .CLK(CLK), .RSTB(RSTB), .EN(EN), .IN(IN), .INV(INV), .IN_VLD(IN_VLD),
        .QN(QN), .OUT_VLD(OUT_VLD), .TGL_CLR(TGL_CLR), .TGL_CNT(TGL_CNT), .TGL_SAT(TGL_SAT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        IN_VLD = 1'b0; EN = 1'b1; TGL_CLR = 1'b0; INV = 1'b0; IN = '0;
        RSTB = 1'b0;
        #3;
        RSTB = 1'b1;
    endtask

    task automatic test_reset;
        RSTB = 1'b0; EN = 1'b1; IN_VLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN = 24'($urandom()); INV = 1'($urandom());
            tick;
            n_chk++; if (QN !== 4'hF) begin n_err++; $display("FAIL rst_qn: got %h expected %h", QN, 4'hF); end
            n_chk++; if (OUT_VLD !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b expected 0", OUT_VLD); end
            n_chk++; if (TGL_CNT !== 16'h0) begin n_err++; $display("FAIL rst_cnt: got %h expected 0000", TGL_CNT); end
            n_chk++; if (TGL_SAT !== 4'h0) begin n_err++; $display("FAIL rst_sat: got %h expected 0", TGL_SAT); end
        end
        IN_VLD = 1'b0;
        RSTB = 1'b1;
    endtask

    task automatic test_latency;
        do_reset;
        IN = 24'h000003; INV = 1'b1; IN_VLD = 1'b1;
        tick;
        IN_VLD = 1'b0;
        n_chk++; if (OUT_VLD !== 1'b0) begin n_err++; $display("FAIL lat_early_vld: got %b expected 0", OUT_VLD); end
        n_chk++; if (QN !== 4'hF) begin n_err++; $display("FAIL lat_early_qn: got %h expected f", QN); end
        tick;
        n_chk++; if (QN !== 4'hE) begin n_err++; $display("FAIL lat_qn: got %h expected e", QN); end
        n_chk++; if (OUT_VLD !== 1'b1) begin n_err++; $display("FAIL lat_vld: got %b expected 1", OUT_VLD); end
        n_chk++; if (TGL_CNT !== 16'h0001) begin n_err++; $display("FAIL lat_cnt: got %h expected 0001", TGL_CNT); end
        tick;
        n_chk++; if (OUT_VLD !== 1'b0) begin n_err++; $display("FAIL lat_bubble_vld: got %b expected 0", OUT_VLD); end
        n_chk++; if (QN !== 4'hE) begin n_err++; $display("FAIL lat_bubble_qn: got %h expected e", QN); end
    endtask

    task automatic test_stall;
        do_reset;
        IN = 24'h000003; INV = 1'b1; IN_VLD = 1'b1;
        tick;
        EN = 1'b0; IN = 24'hFFFFFF; INV = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++; if (QN !== 4'hF) begin n_err++; $display("FAIL stall_qn: got %h expected f", QN); end
            n_chk++; if (OUT_VLD !== 1'b0) begin n_err++; $display("FAIL stall_vld: got %b expected 0", OUT_VLD); end
            n_chk++; if (TGL_CNT !== 16'h0) begin n_err++; $display("FAIL stall_cnt: got %h expected 0000", TGL_CNT); end
        end
        EN = 1'b1; IN_VLD = 1'b0;
        tick;
        n_chk++; if (QN !== 4'hE) begin n_err++; $display("FAIL stall_out_qn: got %h expected e", QN); end
        n_chk++; if (OUT_VLD !== 1'b1) begin n_err++; $display("FAIL stall_out_vld: got %b expected 1", OUT_VLD); end
        n_chk++; if (TGL_CNT !== 16'h0001) begin n_err++; $display("FAIL stall_out_cnt: got %h expected 0001", TGL_CNT); end
        EN = 1'b0; IN_VLD = 1'b1; IN = 24'h0;
        tick; tick;
        n_chk++; if (QN !== 4'hE) begin n_err++; $display("FAIL stall_hold_qn: got %h expected e", QN); end
        n_chk++; if (OUT_VLD !== 1'b1) begin n_err++; $display("FAIL stall_hold_vld: got %b expected 1", OUT_VLD); end
        n_chk++; if (TGL_CNT !== 16'h0001) begin n_err++; $display("FAIL stall_hold_cnt: got %h expected 0001", TGL_CNT); end
        EN = 1'b1; IN_VLD = 1'b0;
        tick;
        n_chk++; if (OUT_VLD !== 1'b0) begin n_err++; $display("FAIL stall_resume_vld: got %b expected 0", OUT_VLD); end
    endtask

    task automatic test_polarity;
        do_reset;
        IN = 24'h0; INV = 1'b0; IN_VLD = 1'b1;
        tick;
        INV = 1'b1;
        tick;
        IN_VLD = 1'b0; INV = 1'b0;
        n_chk++; if (QN !== 4'h0) begin n_err++; $display("FAIL pol_ao_qn: got %h expected 0", QN); end
        n_chk++; if (OUT_VLD !== 1'b1) begin n_err++; $display("FAIL pol_ao_vld: got %b expected 1", OUT_VLD); end
        n_chk++; if (TGL_CNT !== 16'h1111) begin n_err++; $display("FAIL pol_ao_cnt: got %h expected 1111", TGL_CNT); end
        tick;
        n_chk++; if (QN !== 4'hF) begin n_err++; $display("FAIL pol_aoi_qn: got %h expected f", QN); end
        n_chk++; if (TGL_CNT !== 16'h2222) begin n_err++; $display("FAIL pol_aoi_cnt: got %h expected 2222", TGL_CNT); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] v_in  [4] = '{24'h130000, 24'hFFFFFF, 24'h00000C, 24'h0A0A0A};
        logic        v_inv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]  e_qn  [4] = '{4'h4, 4'h0, 4'h1, 4'hF};
        logic [15:0] e_cnt [4] = '{16'h1011, 16'h1111, 16'h1112, 16'h2222};
        do_reset;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                IN = v_in[i]; INV = v_inv[i]; IN_VLD = 1'b1;
            end else begin
                IN_VLD = 1'b0;
            end
            tick;
            if (i >= 1) begin
                n_chk++; if (QN !== e_qn[i-1]) begin n_err++; $display("FAIL b2b_qn[%0d]: got %h expected %h", i-1, QN, e_qn[i-1]); end
                n_chk++; if (OUT_VLD !== 1'b1) begin n_err++; $display("FAIL b2b_vld[%0d]: got %b expected 1", i-1, OUT_VLD); end
                n_chk++; if (TGL_CNT !== e_cnt[i-1]) begin n_err++; $display("FAIL b2b_cnt[%0d]: got %h expected %h", i-1, TGL_CNT, e_cnt[i-1]); end
            end
        end
    endtask

    task automatic test_saturation;
        do_reset;
        INV = 1'b0; IN_VLD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            IN = (i % 2 == 0) ? 24'h000000 : 24'h0000C0;
            tick;
        end
        IN_VLD = 1'b0;
        tick;
        n_chk++; if (TGL_CNT !== 16'h11F1) begin n_err++; $display("FAIL sat_cnt: got %h expected 11f1", TGL_CNT); end
        n_chk++; if (TGL_SAT !== 4'b0010) begin n_err++; $display("FAIL sat_flag: got %b expected 0010", TGL_SAT); end
        n_chk++; if (QN !== 4'h2) begin n_err++; $display("FAIL sat_qn: got %h expected 2", QN); end
        IN = 24'h0; IN_VLD = 1'b1;
        tick;
        IN_VLD = 1'b0; TGL_CLR = 1'b1;
        tick;
        TGL_CLR = 1'b0;
        n_chk++; if (TGL_CNT !== 16'h0) begin n_err++; $display("FAIL clr_cnt: got %h expected 0000", TGL_CNT); end
        n_chk++; if (TGL_SAT !== 4'h0) begin n_err++; $display("FAIL clr_sat: got %b expected 0000", TGL_SAT); end
        n_chk++; if (QN !== 4'h0) begin n_err++; $display("FAIL clr_qn: got %h expected 0", QN); end
        IN = 24'h0000C0; IN_VLD = 1'b1;
        tick;
        IN_VLD = 1'b0;
        tick;
        n_chk++; if (TGL_CNT !== 16'h0010) begin n_err++; $display("FAIL clr_resume_cnt: got %h expected 0010", TGL_CNT); end
        EN = 1'b0; TGL_CLR = 1'b1;
        tick;
        TGL_CLR = 1'b0; EN = 1'b1;
        n_chk++; if (TGL_CNT !== 16'h0) begin n_err++; $display("FAIL clr_stalled_cnt: got %h expected 0000", TGL_CNT); end
    endtask

    task automatic test_reset_midflight;
        do_reset;
        IN = 24'h000003; INV = 1'b1; IN_VLD = 1'b1;
        tick; tick;
        n_chk++; if (QN !== 4'hE) begin n_err++; $display("FAIL mid_pre_qn: got %h expected e", QN); end
        IN_VLD = 1'b0;
        RSTB = 1'b0;
        #1;
        n_chk++; if (QN !== 4'hF) begin n_err++; $display("FAIL mid_async_qn: got %h expected f", QN); end
        n_chk++; if (OUT_VLD !== 1'b0) begin n_err++; $display("FAIL mid_async_vld: got %b expected 0", OUT_VLD); end
        n_chk++; if (TGL_CNT !== 16'h0) begin n_err++; $display("FAIL mid_async_cnt: got %h expected 0000", TGL_CNT); end
        #3;
        RSTB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++; if (OUT_VLD !== 1'b0) begin n_err++; $display("FAIL mid_flush_vld[%0d]: got %b expected 0", i, OUT_VLD); end
            n_chk++; if (QN !== 4'hF) begin n_err++; $display("FAIL mid_flush_qn[%0d]: got %h expected f", i, QN); end
        end
        IN = 24'h0; INV = 1'b0; IN_VLD = 1'b1;
        tick;
        IN_VLD = 1'b0;
        tick;
        n_chk++; if (QN !== 4'h0) begin n_err++; $display("FAIL mid_fresh_qn: got %h expected 0", QN); end
        n_chk++; if (OUT_VLD !== 1'b1) begin n_err++; $display("FAIL mid_fresh_vld: got %b expected 1", OUT_VLD); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_stall;
        test_polarity;
        test_back_to_back;
        test_saturation;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
